// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding control for the 5-stage pipeline: operand forwarding selects,
// load-use and multiply stalls, branch flush, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       ex_rs_i,
    input  logic [4:0]       ex_rt_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_regwrite_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             wb_regwrite_i,
    input  logic             branch_taken_i,
    input  logic             mul_start_i,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_bubble_o,
    output logic             flush_o,
    output logic             mul_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int CW = $clog2(MUL_LAT);
    localparam logic [CW-1:0] CNT_START = CW'(MUL_LAT - 2);

    localparam logic [1:0] SEL_IDEX  = 2'd0;
    localparam logic [1:0] SEL_MEMWB = 2'd1;
    localparam logic [1:0] SEL_EXMEM = 2'd2;

    typedef enum logic {
        RUN,
        MUL_BUSY
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_use;

    // EX/MEM has the younger result, so it wins over MEM/WB; $0 is hardwired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_rw,
        input logic [4:0] wb_rd,
        input logic       wb_rw
    );
        if (mem_rw && mem_rd != 5'd0 && mem_rd == src)
            return SEL_EXMEM;
        else if (wb_rw && wb_rd != 5'd0 && wb_rd == src)
            return SEL_MEMWB;
        else
            return SEL_IDEX;
    endfunction

    assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

    // NOTE: every output gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        fwd_a_sel_o   = SEL_IDEX;
        fwd_b_sel_o   = SEL_IDEX;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b0;
        flush_o       = 1'b0;
        mul_done_o    = 1'b0;

        if (!rst_i) begin
            fwd_a_sel_o = fwd_sel(ex_rs_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);
            fwd_b_sel_o = fwd_sel(ex_rt_i, mem_rd_i, mem_regwrite_i, wb_rd_i, wb_regwrite_i);

            unique case (state)
                RUN: begin
                    if (branch_taken_i) begin
                        flush_o      = 1'b1;
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                    end else if (mul_start_i) begin
                        state_nxt = MUL_BUSY;
                        cnt_nxt   = CNT_START;
                    end else if (load_use) begin
                        idex_bubble_o = 1'b1;
                    end else begin
                        pc_write_o   = 1'b1;
                        ifid_write_o = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    // Branch, new multiply and load-use are all held off while busy.
                    if (cnt == '0) begin
                        mul_done_o = 1'b1;
                        state_nxt  = RUN;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt_o <= '0;
        else if (!pc_write_o && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, multiply stall,
// branch priority, mid-multiply reset and stall counter saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_memread, mem_regwrite, wb_regwrite, branch_taken, mul_start;

    logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic        pc_write, ifid_write, idex_bubble, flush, mul_done;
    logic        s_pc_write, s_ifid_write, s_idex_bubble, s_flush, s_mul_done;
    logic [15:0] stall_cnt;
    logic [1:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
        .branch_taken_i(branch_taken), .mul_start_i(mul_start),
        .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write),
        .idex_bubble_o(idex_bubble), .flush_o(flush),
        .mul_done_o(mul_done), .stall_cnt_o(stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(2)) u_sat (
        .clk_i(clk), .rst_i(rst),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd), .ex_memread_i(ex_memread),
        .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite),
        .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
        .branch_taken_i(branch_taken), .mul_start_i(mul_start),
        .fwd_a_sel_o(s_fwd_a), .fwd_b_sel_o(s_fwd_b),
        .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write),
        .idex_bubble_o(s_idex_bubble), .flush_o(s_flush),
        .mul_done_o(s_mul_done), .stall_cnt_o(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
        mem_rd = 5'd0; wb_rd = 5'd0;
        ex_memread = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        branch_taken = 1'b0; mul_start = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset: outputs forced low even with a forwarding match present.
        mem_rd = 5'd5; mem_regwrite = 1'b1; ex_rs = 5'd5;
        #2;
        check("rst_pc_write",   32'(pc_write),   0);
        check("rst_ifid_write", 32'(ifid_write), 0);
        check("rst_stall_cnt",  32'(stall_cnt),  0);
        check("rst_fwd_a",      32'(fwd_a),      0);
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("idle_pc_write",   32'(pc_write),   1);
        check("idle_ifid_write", 32'(ifid_write), 1);
        check("idle_flush",      32'(flush),      0);

        // Forwarding.
        mem_rd = 5'd5; wb_rd = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        ex_rs = 5'd5; ex_rt = 5'd0;
        #1;
        check("fwd_a_exmem", 32'(fwd_a), 2);
        check("fwd_b_none",  32'(fwd_b), 0);
        ex_rt = 5'd5;
        #1;
        check("fwd_b_exmem", 32'(fwd_b), 2);
        mem_regwrite = 1'b0;
        #1;
        check("fwd_a_memwb", 32'(fwd_a), 1);
        mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rt = 5'd7; wb_rd = 5'd7;
        #1;
        check("fwd_a_other_rd", 32'(fwd_a), 0);
        check("fwd_b_memwb",    32'(fwd_b), 1);
        mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
        #1;
        check("fwd_a_zero_reg", 32'(fwd_a), 0);
        check("fwd_b_zero_reg", 32'(fwd_b), 0);
        idle_inputs();
        tick();
        check("fwd_no_stall", 32'(stall_cnt), 0);

        // Load-use: exactly one bubble.
        ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8;
        #1;
        check("lu_pc_write",   32'(pc_write),    0);
        check("lu_ifid_write", 32'(ifid_write),  0);
        check("lu_bubble",     32'(idex_bubble), 1);
        tick();
        idle_inputs();
        #1;
        check("lu_after_pc_write", 32'(pc_write),    1);
        check("lu_after_bubble",   32'(idex_bubble), 0);
        check("lu_stall_cnt",      32'(stall_cnt),   1);
        check("lu_sat_cnt",        32'(s_stall_cnt), 1);

        // Multiply: four stall cycles, done in the last one; branch ignored while busy.
        mul_start = 1'b1;
        #1;
        check("mul_c1_pc_write", 32'(pc_write), 0);
        check("mul_c1_done",     32'(mul_done), 0);
        tick();
        mul_start = 1'b0; branch_taken = 1'b1;
        #1;
        check("mul_c2_pc_write", 32'(pc_write), 0);
        check("mul_c2_flush",    32'(flush),    0);
        check("mul_c2_done",     32'(mul_done), 0);
        tick();
        branch_taken = 1'b0;
        #1;
        check("mul_c3_pc_write", 32'(pc_write), 0);
        check("mul_c3_done",     32'(mul_done), 0);
        tick();
        check("mul_c4_pc_write", 32'(pc_write), 0);
        check("mul_c4_done",     32'(mul_done), 1);
        tick();
        check("mul_end_pc_write", 32'(pc_write),    1);
        check("mul_end_done",     32'(mul_done),    0);
        check("mul_stall_cnt",    32'(stall_cnt),   5);
        check("sat_holds_3",      32'(s_stall_cnt), 3);

        // Branch beats multiply start and load-use together.
        branch_taken = 1'b1; mul_start = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8;
        #1;
        check("br_flush",     32'(flush),       1);
        check("br_pc_write",  32'(pc_write),    1);
        check("br_ifid",      32'(ifid_write),  1);
        check("br_bubble",    32'(idex_bubble), 0);
        tick();
        idle_inputs();
        #1;
        check("br_stay_run", 32'(pc_write),  1);
        check("br_no_done",  32'(mul_done),  0);
        check("br_no_stall", 32'(stall_cnt), 5);
        tick();
        check("sat_still_3", 32'(s_stall_cnt), 3);

        // Reset in the second multiply cycle aborts it without a done pulse.
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        #1;
        check("abort_busy_pc_write", 32'(pc_write),  0);
        check("abort_busy_cnt",      32'(stall_cnt), 6);
        rst = 1'b1;
        #1;
        check("abort_rst_cnt",  32'(stall_cnt), 0);
        check("abort_rst_done", 32'(mul_done),  0);
        check("abort_rst_pc",   32'(pc_write),  0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_run_pc_write", 32'(pc_write),  1);
        check("abort_run_cnt",      32'(stall_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", 32'(mul_done), 0);
            check("abort_no_stall", 32'(pc_write), 1);
            tick();
        end
        check("abort_final_cnt", 32'(stall_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule
